muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the shared multiplier/divider pair and the HI/LO registers for the multi-cycle CPU.
//  Accepts one MULT/DIV request at a time from controlUnit and issues the start pulse to the selected unit.
//  Waits for that unit's ready, then commits both HI and LO through a single write strobe.
//  Also reports divide-by-zero, stalls MFHI/MFLO while an operation is in flight, and raises
//  a watchdog error when that feature is compiled in.
// PARAMETERS
//  START_CYCLES    1   cycles mult_start/div_start is held high (1..2**CNT_W-1)
//  TIMEOUT_CYCLES  64  max WAIT cycles before err_timeout (used only with MULDIV_TIMEOUT_EN)
//  CNT_W           7   cycle counter width; must hold max(START_CYCLES, TIMEOUT_CYCLES)
// PORTS
//  clk          in   1  clock; all state changes on the rising edge
//  reset        in   1  asynchronous, active-low reset
//  req_valid    in   1  controlUnit requests an operation
//  req_op       in   1  0 = MULT, 1 = DIV; sampled only with req_valid while req_ready=1
//  req_ready    out  1  sequencer is in IDLE and accepts a request
//  mult_start   out  1  start strobe to the multiplier
//  mult_ready   in   1  multiplier result valid
//  div_start    out  1  start strobe to the divider
//  div_ready    in   1  divider result valid
//  div_zero     in   1  divisor-is-zero flag from the divider
//  hi_wr        out  1  HI register load enable
//  lo_wr        out  1  LO register load enable
//  hilo_sel     out  1  HI/LO input mux select (0 = multiplier, 1 = divider)
//  hilo_read    in   1  controlUnit is executing MFHI/MFLO this cycle
//  stall        out  1  = hilo_read & busy (combinational)
//  busy         out  1  high in every state except IDLE
//  done         out  1  one-cycle pulse when a result is committed
//  exc_div0     out  1  one-cycle pulse when a DIV is aborted on divisor = 0
//  err_timeout  out  1  one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE; counter=0; op=0; hilo_sel=0; all strobes and pulses 0.
//  Reset asserted mid-operation: the operation is dropped, no HI/LO write occurs, and the block restarts in IDLE.
//  FSM states: IDLE, ISSUE, WAIT, COMMIT, ABORT.
//   IDLE:   req_ready=1. If req_valid=1: latch op=req_op, clear counter, go to ISSUE.
//   ISSUE:  assert start for the latched op only; counter increments each cycle.
//           DIV with div_zero=1 in the first ISSUE cycle: go to ABORT (start is not asserted that cycle).
//           Otherwise go to WAIT when counter == START_CYCLES-1, and clear the counter.
//   WAIT:   sample only the selected unit's ready; the other unit's ready is ignored.
//           ready=1: go to COMMIT. Ready during ISSUE is ignored.
//   COMMIT: hi_wr=lo_wr=1 and done=1 for exactly one cycle; hilo_sel=op; go to IDLE.
//   ABORT:  exc_div0=1 for one cycle; HI/LO are not written; go to IDLE.
//  hilo_sel is registered: updated on entry to COMMIT and held stable until the next COMMIT.
//  Latency:
//   - minimum request-to-done is START_CYCLES+2 cycles (ready high in the first WAIT cycle);
//   - ABORT pulses on cycle 2 after acceptance.
//  req_valid while busy=1: ignored, with no queuing; controlUnit must hold it until accepted.
//  Request accepted: req_ready drops on the cycle after acceptance.
//  A new request may be accepted in the IDLE cycle that immediately follows COMMIT or ABORT.
//  stall is combinational; MFHI/MFLO in the COMMIT cycle still stall, so a read never sees stale data.
//  Counter saturates at 2**CNT_W-1 and never wraps.
// CONFIGURATION
//  `MULDIV_TIMEOUT_EN defined:
//   - WAIT exits to IDLE when counter == TIMEOUT_CYCLES-1 with ready still 0;
//   - err_timeout pulses for one cycle and HI/LO are not written;
//   - ready and the timeout in the same cycle: ready wins and the block goes to COMMIT.
//  `MULDIV_TIMEOUT_EN undefined:
//   - WAIT holds indefinitely until ready arrives;
//   - err_timeout is tied to 0.
// STRUCTURE
//  muldiv_pkg holds:
//   - state encodings (IDLE=3'd0, ISSUE=3'd1, WAIT=3'd2, COMMIT=3'd3, ABORT=3'd4);
//   - OP_MULT=1'b0, OP_DIV=1'b1;
//   - default TIMEOUT_CYCLES.
//  One sub-module: muldiv_cycle_counter (clear, enable, saturating count, terminal-compare output).
//   It serves both the start-pulse length and the watchdog.
// TESTING
//  1. MULT, START_CYCLES=1, mult_ready 3 cycles into WAIT
//     -> mult_start high for 1 cycle; hi_wr=lo_wr=done for 1 cycle; hilo_sel=0.
//  2. DIV, divisor nonzero, div_ready in the first WAIT cycle -> done on cycle 3 after acceptance; hilo_sel=1.
//  3. DIV with div_zero=1 -> exc_div0 pulse on cycle 2; div_start, hi_wr and lo_wr never assert.
//  4. hilo_read during WAIT and during COMMIT -> stall=1; hilo_read in the IDLE cycle after COMMIT -> stall=0.
//  5. reset=0 mid-WAIT, then mult_ready=1 -> no hi_wr; outputs read 0; req_ready=1 after release.
//  6. `MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready never arrives
//     -> err_timeout pulses exactly once, 8 cycles into WAIT; no HI/LO write.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encodings,
// operation codes and default parameter values.
// Latency: n/a (definitions only). Backpressure: n/a.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEF_START_CYCLES   = 1;
    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_CNT_W          = 7;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Saturating cycle counter with synchronous clear and a terminal-value compare.
// Latency: count updates on the clock edge after clr/en; at_term is combinational from count.
// Backpressure: none; en simply freezes the count when low, and it sticks at all-ones.
// Ports: clk, reset (async active-low), clr, en, term (compare value) -> count, at_term.
module muldiv_cycle_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV at a time: start pulse, wait for unit ready, commit HI/LO together.
// Latency: request-to-done START_CYCLES+2 cycles minimum; divide-by-zero abort pulses 2 cycles after accept.
// Backpressure: req_ready only in IDLE; requests while busy are ignored, caller holds req_valid.
// Ports: req_valid/req_op/req_ready (controlUnit handshake), mult_start/mult_ready and
//        div_start/div_ready/div_zero (unit control), hi_wr/lo_wr/hilo_sel (HI/LO regs),
//        hilo_read -> stall, busy, done, exc_div0, err_timeout (status).
// Optional watchdog compiled in with MULDIV_TIMEOUT_EN; otherwise err_timeout is tied low.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int START_CYCLES   = DEF_START_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic mult_start,
    input  logic mult_ready,
    output logic div_start,
    input  logic div_ready,
    input  logic div_zero,
    output logic hi_wr,
    output logic lo_wr,
    output logic hilo_sel,
    input  logic hilo_read,
    output logic stall,
    output logic busy,
    output logic done,
    output logic exc_div0,
    output logic err_timeout
);

    localparam logic [CNT_W-1:0] START_TERM   = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic             op_q;
    logic             hilo_sel_q;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] cnt;
    logic             cnt_at_term;
    logic             sel_ready;

    // One counter serves both phases: start-pulse length in ISSUE, watchdog in WAIT.
    muldiv_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .term    (cnt_term),
        .count   (cnt),
        .at_term (cnt_at_term)
    );

    // Only the unit that was started is listened to.
    assign sel_ready = (op_q == OP_DIV) ? div_ready : mult_ready;

`ifdef MULDIV_TIMEOUT_EN
    logic tmo_d;
    logic tmo_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        cnt_term   = START_TERM;
        mult_start = 1'b0;
        div_start  = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        tmo_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ISSUE;
                    cnt_clr = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Zero divisor is only honoured on the first ISSUE cycle (count still 0),
                // and the divider is never started for it.
                if ((op_q == OP_DIV) && div_zero && (cnt == '0)) begin
                    state_d = ST_ABORT;
                end else begin
                    mult_start = (op_q == OP_MULT);
                    div_start  = (op_q == OP_DIV);
                    if (cnt_at_term) begin
                        state_d = ST_WAIT;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_term = TIMEOUT_TERM;
                cnt_en   = 1'b1;
                if (sel_ready) begin
                    state_d = ST_COMMIT;
`ifdef MULDIV_TIMEOUT_EN
                end else if (cnt_at_term) begin
                    // Ready takes priority; watchdog only fires with ready still low.
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
`endif
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MULT;
            hilo_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && req_valid) begin
                op_q <= req_op;
            end
            // HI/LO mux select follows the op only when a result is actually committed,
            // so an aborted or timed-out op leaves it untouched.
            if ((state_d == ST_COMMIT) && (state_q != ST_COMMIT)) begin
                hilo_sel_q <= op_q;
            end
        end
    end

`ifdef MULDIV_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign err_timeout = tmo_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_COMMIT);
    assign hi_wr     = done;
    assign lo_wr     = done;
    assign exc_div0  = (state_q == ST_ABORT);
    assign hilo_sel  = hilo_sel_q;
    // Includes COMMIT, so an MFHI/MFLO never reads the pre-commit value.
    assign stall     = hilo_read & busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed ops with a scoreboard of expected
// done / exc_div0 / err_timeout events, checked by an independent monitor.
// Latency: n/a. Backpressure: n/a.
module tb_muldiv_sequencer;

    logic clk;
    logic reset;
    logic req_valid, req_op, req_ready;
    logic mult_start, mult_ready, div_start, div_ready, div_zero;
    logic hi_wr, lo_wr, hilo_sel, hilo_read, stall, busy, done, exc_div0, err_timeout;

    muldiv_sequencer #(
        .START_CYCLES   (1),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_ready   (req_ready),
        .mult_start  (mult_start),
        .mult_ready  (mult_ready),
        .div_start   (div_start),
        .div_ready   (div_ready),
        .div_zero    (div_zero),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .hilo_sel    (hilo_sel),
        .hilo_read   (hilo_read),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .exc_div0    (exc_div0),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event kinds: 0 = done/commit, 1 = exc_div0, 2 = err_timeout
    typedef struct {
        int   kind;
        logic sel;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_ms = 0, n_ds = 0, n_hw = 0, n_lw = 0;
    logic last_sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: strobe counters plus scoreboard comparison on every status event.
    always @(negedge clk) begin
        if (mult_start) n_ms++;
        if (div_start)  n_ds++;
        if (hi_wr)      n_hw++;
        if (lo_wr)      n_lw++;
        if (done || exc_div0 || err_timeout) begin
            int   kind;
            exp_t e;
            kind = done ? 0 : (exc_div0 ? 1 : 2);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
            end else begin
                e = sb.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (e.kind == 0) begin
                    chk("commit_hilo_sel", hilo_sel, e.sel);
                    chk("commit_hi_wr", hi_wr, 1);
                    chk("commit_lo_wr", lo_wr, 1);
                end
            end
        end
    end

    // Runs one request starting in an IDLE cycle (called #1 after a rising edge).
    // delay = WAIT cycles with ready low before the selected ready rises.
    // other = level driven on the non-selected unit's ready throughout.
    task automatic run_op(input logic op, input logic zero, input int delay, input logic other);
        int   acc, b_ms, b_ds, b_hw, b_lw;
        exp_t e;
        hilo_read = 1'b1;
        if (op) mult_ready = other; else div_ready = other;
        req_valid = 1'b1;
        req_op    = op;
        div_zero  = zero;
        #1;
        chk("req_ready_idle", req_ready, 1);
        chk("stall_idle", stall, 0);
        acc = cyc; b_ms = n_ms; b_ds = n_ds; b_hw = n_hw; b_lw = n_lw;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_ready_issue", req_ready, 0);
        chk("stall_issue", stall, 1);
        if (zero) begin
            e.kind = 1; e.sel = 1'b0; e.cyc = acc + 2;
            sb.push_back(e);
            @(posedge clk); #1;
            div_zero = 1'b0;
        end else begin
            e.kind = 0; e.sel = op; e.cyc = acc + 3 + delay;
            sb.push_back(e);
            repeat (1 + delay) @(posedge clk);
            #1;
            chk("stall_wait", stall, 1);
            chk("busy_wait", busy, 1);
            if (op) div_ready = 1'b1; else mult_ready = 1'b1;
            @(posedge clk); #1;
            mult_ready = 1'b0;
            div_ready  = 1'b0;
            chk("stall_commit", stall, 1);
            last_sel = op;
        end
        @(posedge clk); #1;
        mult_ready = 1'b0;
        div_ready  = 1'b0;
        chk("stall_after", stall, 0);
        chk("hilo_sel_hold", hilo_sel, last_sel);
        chk("mult_start_cnt", n_ms - b_ms, (op == 1'b0) ? 1 : 0);
        chk("div_start_cnt", n_ds - b_ds, (op == 1'b1 && !zero) ? 1 : 0);
        chk("hi_wr_cnt", n_hw - b_hw, zero ? 0 : 1);
        chk("lo_wr_cnt", n_lw - b_lw, zero ? 0 : 1);
        hilo_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int b_hw;
        reset = 1'b0; req_valid = 1'b0; req_op = 1'b0;
        mult_ready = 1'b0; div_ready = 1'b0; div_zero = 1'b0; hilo_read = 1'b0;
        #3;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_hilo_sel", hilo_sel, 0);
        chk("rst_strobes", {mult_start, div_start, hi_wr, lo_wr, done, exc_div0, err_timeout}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 1'b0, 3, 1'b1);   // MULT, ready 3 cycles into WAIT, div_ready ignored
        run_op(1'b1, 1'b0, 0, 1'b1);   // DIV, ready first WAIT cycle, back-to-back accept
        run_op(1'b1, 1'b1, 0, 1'b0);   // DIV by zero -> abort, hilo_sel unchanged
        run_op(1'b0, 1'b0, 0, 1'b0);   // MULT minimum latency
        run_op(1'b1, 1'b0, 2, 1'b0);   // DIV leaves hilo_sel=1 before reset test

        // Reset asserted mid-WAIT with the multiplier reporting ready
        req_valid = 1'b1; req_op = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_hw = n_hw;
        reset = 1'b0;
        mult_ready = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_hilo_sel", hilo_sel, 0);
        chk("midrst_strobes", {mult_start, div_start, hi_wr, lo_wr, done, exc_div0}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        last_sel = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mult_ready = 1'b0;
        chk("midrst_no_hi_wr", n_hw - b_hw, 0);
        chk("midrst_idle", busy, 0);

`ifdef MULDIV_TIMEOUT_EN
        begin
            int   acc;
            exp_t e;
            req_valid = 1'b1; req_op = 1'b0;
            #1;
            acc = cyc; b_hw = n_hw;
            @(posedge clk); #1;
            req_valid = 1'b0;
            e.kind = 2; e.sel = 1'b0; e.cyc = acc + 10;
            sb.push_back(e);
            repeat (11) @(posedge clk);
            #1;
            chk("tmo_idle", busy, 0);
            chk("tmo_no_hi_wr", n_hw - b_hw, 0);
        end
`else
        run_op(1'b0, 1'b0, 20, 1'b0);  // WAIT well beyond 8 cycles, no watchdog built in
`endif
        run_op(1'b1, 1'b0, 1, 1'b0);   // recovery after reset / long wait

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
